// File: rtl/alu_driver_if.sv
// Bundles the three alu_driver buses: command handshake, ALU drive/result, response handshake.
// The 'slave' modport is the alu_driver side: it accepts commands, drives the ALU, and offers responses.
// The 'master' modport is the environment side: it issues commands, models the ALU, and sinks responses.
interface alu_driver_if;
  // command handshake
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  // ALU drive and result
  logic [3:0] alu_inp1;
  logic [3:0] alu_inp2;
  logic [1:0] alu_select;
  logic [7:0] alu_out;
  logic       alu_cout;
  // response handshake
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_cout, rsp_ready,
    output cmd_ready, alu_inp1, alu_inp2, alu_select, rsp_valid, rsp_data, rsp_cout
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_cout, rsp_ready,
    input  cmd_ready, alu_inp1, alu_inp2, alu_select, rsp_valid, rsp_data, rsp_cout
  );
endinterface

// File: rtl/alu_driver.sv
// Purpose: sequences one command at a time onto an external ALU, samples its result and hands it back.
// Latency: command accepted at edge E0 gives rsp_valid from edge E0+SETTLE_CYCLES; spacing >= SETTLE_CYCLES+2.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready, then back to IDLE.
//
// Ports: clk, rst_n (async active-low); bus (alu_driver_if.slave: cmd_*, alu_*, rsp_*);
//        op_count (CNT_W, wrapping count of sampled results); busy (high outside IDLE).
// Optional feature: define ALU_DRIVER_ACC_EN to turn cmd_op 2'b11 into accumulate
//        (alu_inp1 = accumulator, alu_inp2 = cmd_b, add); the accumulator keeps the low
//        nibble of every sampled result. Without it cmd_op 2'b11 passes straight to alu_select.
module alu_driver #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_driver_if.slave      bus,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  // Out-of-range settle times collapse to the one-cycle default.
  localparam int         SETTLE_EFF = (SETTLE_CYCLES >= 1 && SETTLE_CYCLES <= 15) ? SETTLE_CYCLES : 1;
  localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_EFF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       sample;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [3:0] settle_cnt;
  logic [3:0] inp1_q;
  logic [3:0] inp2_q;
  logic [1:0] sel_q;
  logic [7:0] rsp_data_q;
  logic       rsp_cout_q;
`ifdef ALU_DRIVER_ACC_EN
  logic [3:0] acc_q;
`endif

  // State register: reset lands in IDLE asynchronously, so cmd_ready is high even while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    sample    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        // The edge that takes the counter from 1 to 0 is the sample edge.
        if (settle_cnt == 4'd1) begin
          sample    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand latches only move on accept, so the ALU inputs stay put between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 4'd0;
      inp1_q     <= 4'd0;
      inp2_q     <= 4'd0;
      sel_q      <= 2'b00;
      rsp_data_q <= 8'h00;
      rsp_cout_q <= 1'b0;
      op_count   <= '0;
`ifdef ALU_DRIVER_ACC_EN
      acc_q      <= 4'd0;
`endif
    end else begin
      if (accept) begin
        settle_cnt <= SETTLE_LD;
        inp2_q     <= bus.cmd_b;
`ifdef ALU_DRIVER_ACC_EN
        if (bus.cmd_op == 2'b11) begin
          inp1_q <= acc_q;
          sel_q  <= 2'b00;
        end else begin
          inp1_q <= bus.cmd_a;
          sel_q  <= bus.cmd_op;
        end
`else
        inp1_q     <= bus.cmd_a;
        sel_q      <= bus.cmd_op;
`endif
      end else if (state == DRIVE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end

      if (sample) begin
        rsp_data_q <= bus.alu_out;
        rsp_cout_q <= bus.alu_cout;
        op_count   <= op_count + 1'b1;
`ifdef ALU_DRIVER_ACC_EN
        acc_q      <= bus.alu_out[3:0];
`endif
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.alu_inp1   = inp1_q;
  assign bus.alu_inp2   = inp2_q;
  assign bus.alu_select = sel_q;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: instance 0 uses SETTLE_CYCLES=1, instance 1 uses SETTLE_CYCLES=4.
// Each instance sees a behavioural ALU (select 00 -> a+b, otherwise a-b); a per-command
// scoreboard predicts the response from the command fields alone.
module tb_alu_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [2];
  logic       cmd_valid [2];
  logic [1:0] cmd_op    [2];
  logic [3:0] cmd_a     [2];
  logic [3:0] cmd_b     [2];
  logic       rsp_ready [2];

  logic       rdy_o   [2];
  logic       rvld_o  [2];
  logic       rcout_o [2];
  logic       busy_o  [2];
  logic [7:0] rdat_o  [2];
  logic [7:0] cnt_o   [2];
  logic [3:0] in1_o   [2];
  logic [3:0] in2_o   [2];
  logic [1:0] sel_o   [2];

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_cnt [2];
  logic [3:0] acc     [2];

  function automatic logic [8:0] alu_model(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] r;
    logic       c;
    if (s == 2'b00) begin
      r = {4'd0, a} + {4'd0, b};
      c = r[4];
    end else begin
      r = {4'd0, a} - {4'd0, b};
      c = (a < b);
    end
    return {c, r};
  endfunction

  alu_driver_if u_if [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign u_if[g].cmd_valid = cmd_valid[g];
    assign u_if[g].cmd_op    = cmd_op[g];
    assign u_if[g].cmd_a     = cmd_a[g];
    assign u_if[g].cmd_b     = cmd_b[g];
    assign u_if[g].rsp_ready = rsp_ready[g];
    assign {u_if[g].alu_cout, u_if[g].alu_out} =
        alu_model(u_if[g].alu_select, u_if[g].alu_inp1, u_if[g].alu_inp2);
    assign rdy_o[g]   = u_if[g].cmd_ready;
    assign rvld_o[g]  = u_if[g].rsp_valid;
    assign rdat_o[g]  = u_if[g].rsp_data;
    assign rcout_o[g] = u_if[g].rsp_cout;
    assign in1_o[g]   = u_if[g].alu_inp1;
    assign in2_o[g]   = u_if[g].alu_inp2;
    assign sel_o[g]   = u_if[g].alu_select;

    alu_driver #(
      .SETTLE_CYCLES(g == 0 ? 1 : 4),
      .CNT_W        (8)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .bus     (u_if[g]),
      .op_count(cnt_o[g]),
      .busy    (busy_o[g])
    );
  end

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic check_reset_vals(input int d);
    check("rst_cmd_ready", 32'(rdy_o[d]), 1);
    check("rst_rsp_valid", 32'(rvld_o[d]), 0);
    check("rst_rsp_data", 32'(rdat_o[d]), 0);
    check("rst_rsp_cout", 32'(rcout_o[d]), 0);
    check("rst_inp1", 32'(in1_o[d]), 0);
    check("rst_inp2", 32'(in2_o[d]), 0);
    check("rst_select", 32'(sel_o[d]), 0);
    check("rst_op_count", 32'(cnt_o[d]), 0);
    check("rst_busy", 32'(busy_o[d]), 0);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    @(negedge clk);
    check_reset_vals(d);
    rst_n[d]   = 1'b1;
    exp_cnt[d] = 8'd0;
    acc[d]     = 4'd0;
    @(negedge clk);
  endtask

  task automatic junk_cmd(input int d);
    cmd_valid[d] = 1'($urandom);
    cmd_op[d]    = 2'($urandom);
    cmd_a[d]     = 4'($urandom);
    cmd_b[d]     = 4'($urandom);
  endtask

  // One complete transaction: offer, check latency and ALU drive, hold response, complete.
  task automatic do_op(input int d, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input int hold);
    logic [3:0] a_eff;
    logic [1:0] sel;
    int         v;
    logic [7:0] want_d;
    logic       want_c;
    int         lat;
    a_eff = a;
    sel   = op;
`ifdef ALU_DRIVER_ACC_EN
    if (op == 2'b11) begin
      a_eff = acc[d];
      sel   = 2'b00;
    end
`endif
    v      = (sel == 2'b00) ? (int'(a_eff) + int'(b)) : (int'(a_eff) - int'(b));
    want_d = 8'(v);
    want_c = (sel == 2'b00) ? (v > 15) : (v < 0);

    check("idle_ready", 32'(rdy_o[d]), 1);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    check("busy_after_accept", 32'(busy_o[d]), 1);
    check("ready_low_busy", 32'(rdy_o[d]), 0);

    lat = 0;
    while (!rvld_o[d] && lat < 40) begin
      check("drive_inp1", 32'(in1_o[d]), 32'(a_eff));
      check("drive_inp2", 32'(in2_o[d]), 32'(b));
      check("drive_select", 32'(sel_o[d]), 32'(sel));
      junk_cmd(d);
      @(negedge clk);
      lat++;
    end
    cmd_valid[d] = 1'b0;
    check("latency", 32'(lat), 32'(settle_of(d)));

    exp_cnt[d] = exp_cnt[d] + 8'd1;
    acc[d]     = want_d[3:0];
    check("rsp_data", 32'(rdat_o[d]), 32'(want_d));
    check("rsp_cout", 32'(rcout_o[d]), 32'(want_c));
    check("op_count", 32'(cnt_o[d]), 32'(exp_cnt[d]));

    for (int i = 0; i < hold; i++) begin
      junk_cmd(d);
      @(negedge clk);
      check("hold_valid", 32'(rvld_o[d]), 1);
      check("hold_data", 32'(rdat_o[d]), 32'(want_d));
      check("hold_ready_low", 32'(rdy_o[d]), 0);
      check("hold_count", 32'(cnt_o[d]), 32'(exp_cnt[d]));
    end

    cmd_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("done_valid_low", 32'(rvld_o[d]), 0);
    check("done_ready_high", 32'(rdy_o[d]), 1);
    check("done_count", 32'(cnt_o[d]), 32'(exp_cnt[d]));
    check("idle_inp1_held", 32'(in1_o[d]), 32'(a_eff));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      cmd_valid[d] = 1'b0;
      cmd_op[d]    = 2'b00;
      cmd_a[d]     = 4'd0;
      cmd_b[d]     = 4'd0;
      rsp_ready[d] = 1'b0;
      exp_cnt[d]   = 8'd0;
      acc[d]       = 4'd0;
    end
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // Directed: add with immediate ready, subtract with a long stall, op 11.
    do_op(0, 2'b00, 4'd3, 4'd5, 0);
    do_op(0, 2'b01, 4'd9, 4'd4, 5);
    do_op(0, 2'b11, 4'd6, 4'd2, 0);

    // Reset in the middle of DRIVE on the slow instance: no response may ever appear.
    cmd_valid[1] = 1'b1;
    cmd_op[1]    = 2'b00;
    cmd_a[1]     = 4'd7;
    cmd_b[1]     = 4'd1;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_drive_busy", 32'(busy_o[1]), 1);
    #1 rst_n[1] = 1'b0;
    #1 check_reset_vals(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rvld_o[1]), 0);
    end
    check("post_rst_count", 32'(cnt_o[1]), 32'(exp_cnt[1]));

    // Slow instance: add 7+1 with a four-cycle settle.
    do_op(1, 2'b00, 4'd7, 4'd1, 0);

`ifdef ALU_DRIVER_ACC_EN
    do_reset(0);
    do_op(0, 2'b00, 4'd2, 4'd3, 0);
    do_op(0, 2'b11, 4'd0, 4'd4, 0);
`endif

    // Random traffic on both instances.
    for (int i = 0; i < 30; i++) begin
      do_op(0, 2'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 15; i++) begin
      do_op(1, 2'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    // Counter wrap: exactly 256 operations from reset.
    do_reset(0);
    for (int i = 0; i < 256; i++) begin
      do_op(0, 2'($urandom), 4'($urandom), 4'($urandom), 0);
    end
    check("wrap_count", 32'(cnt_o[0]), 32'(exp_cnt[0]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles operands are held on the ALU before the result is sampled; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of the completed-operation counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have ports cmd_op  input  2, cmd_a  input  4, cmd_b  input  4  operation select and operands.
REQ-008 SHALL have ports alu_inp1  output  4, alu_inp2  output  4, alu_select  output  2  drive to the ALU.
REQ-009 SHALL have ports alu_out  input  8, alu_cout  input  1  ALU result and carry/borrow.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  8, rsp_cout  output  1  result handshake.
REQ-011 SHALL have ports op_count  output  CNT_W  completed operations; busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, DRIVE, RESP; cmd_ready high only in IDLE; rsp_valid high only in RESP.
REQ-013 IDLE: on cmd_valid&cmd_ready, latch cmd_op/cmd_a/cmd_b, load settle counter with SETTLE_CYCLES, go DRIVE.
REQ-014 alu_inp1/alu_inp2/alu_select SHALL come from the latched registers, stable from the accept edge until the next accept; hold last values in IDLE.
REQ-015 DRIVE: counter decrements each edge; on the edge where it reaches 0, sample alu_out into rsp_data and alu_cout into rsp_cout, increment op_count, go RESP.
REQ-016 Latency: command accepted at edge E0 SHALL give rsp_valid high from edge E0+SETTLE_CYCLES (default: next edge).
REQ-017 RESP: rsp_data/rsp_cout SHALL hold stable while rsp_valid is high and rsp_ready is low; on rsp_ready high, go IDLE at that edge.
REQ-018 A new command SHALL NOT be accepted in the same cycle a response completes (cmd_ready low in RESP); minimum command spacing SETTLE_CYCLES+2 cycles.
REQ-019 cmd_valid/cmd_* changes while busy SHALL have no effect.
REQ-020 op_count SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-021 SETTLE_CYCLES values outside 1..15 SHALL be treated as 1.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE regardless of edge or state, including mid-DRIVE or mid-RESP; the in-flight command is discarded with no response.
REQ-023 Reset values: cmd_ready 1 after release (0 while rst_n low acceptable only if combinationally derived from IDLE — SHALL be 1), rsp_valid 0, rsp_data 8'h00, rsp_cout 0, alu_inp1 0, alu_inp2 0, alu_select 2'b00, op_count 0, busy 0, accumulator 0.

Configuration
REQ-024 Macro ALU_DRIVER_ACC_EN SHALL, when defined, make cmd_op 2'b11 an accumulate op: alu_inp1 = accumulator, alu_inp2 = cmd_b, alu_select 2'b00; accumulator loads rsp_data[3:0] at every sample edge of any op.
REQ-025 Without ALU_DRIVER_ACC_EN, cmd_op 2'b11 SHALL be passed to alu_select unchanged with cmd_a as alu_inp1, and no accumulator register SHALL exist.

Verification (behavioural ALU model: select 00 -> zero-extended a+b, else a-b)
REQ-026 Reset then add a=3,b=5, rsp_ready=1 -> rsp_valid 1 cycle after accept, rsp_data 8'h08, op_count 1, cmd_ready back high next cycle.
REQ-027 Sub a=9,b=4 with rsp_ready held low 5 cycles -> rsp_data 8'h05 stable all 5 cycles, cmd_valid toggling ignored, one response only.
REQ-028 SETTLE_CYCLES=4, add a=7,b=1 -> alu_* stable 4 cycles, rsp_valid at accept+4, rsp_data 8'h08.
REQ-029 rst_n low mid-DRIVE (SETTLE_CYCLES=4, after 2 cycles) -> rsp_valid never asserts, all outputs at reset values, op_count unchanged at 0.
REQ-030 With ALU_DRIVER_ACC_EN: add 2+3 then op 11 b=4 -> second alu_inp1 = 5, rsp_data 8'h09; 256 ops with CNT_W=8 -> op_count 0.
